// File: rtl/pc_seq_pkg.sv
// Shared defaults and state encoding for the program sequencer and its return stack.
package pc_seq_pkg;

  localparam int ADDR_W_DEF      = 8;
  localparam int STEP_DEF        = 4;
  localparam int STACK_DEPTH_DEF = 4;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

endpackage

// File: rtl/pc_return_stack.sv
// LIFO of return addresses; only the pointer is reset, entry contents are don't-care.
module pc_return_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic [PTR_W:0]   depth,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   count;
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] top_idx;

  assign wr_idx  = count[PTR_W-1:0];
  assign top_idx = wr_idx - PTR_W'(1);
  assign top     = mem[top_idx];
  assign depth   = count;
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + (PTR_W+1)'(1);
    end else if (pop && !empty) begin
      count <= count - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/program_sequencer.sv
// Program counter with jump/call/return, a bounded return stack and a RUN/HALT FSM.
module program_sequencer
  import pc_seq_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int STEP        = STEP_DEF,
  parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           inc,
  input  logic                           jmp,
  input  logic                           call,
  input  logic                           ret,
  input  logic [ADDR_W-1:0]              jmp_add,
  input  logic                           halt,
  input  logic                           resume,
  output logic [ADDR_W-1:0]              add,
  output logic                           halted,
  output logic [$clog2(STACK_DEPTH):0]   depth,
  output logic                           ovf,
  output logic                           unf
);

  localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] add_nxt;
  logic [ADDR_W-1:0] top;
  logic              push, pop, full, empty;
  logic              ovf_set, unf_set;

  pc_return_stack #(
    .WIDTH (ADDR_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (add + STEP_V),
    .top       (top),
    .depth     (depth),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      add   <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      state <= state_nxt;
      add   <= add_nxt;
      if (ovf_set) ovf <= 1'b1;
      if (unf_set) unf <= 1'b1;
    end
  end

  // One action per cycle in RUN; HALT only listens for resume.
  always_comb begin
    state_nxt = state;
    add_nxt   = add;
    push      = 1'b0;
    pop       = 1'b0;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    case (state)
      RUN: begin
        if (halt) begin
          state_nxt = HALT;
        end else if (jmp) begin
          add_nxt = jmp_add;
        end else if (call) begin
          if (full) begin
            ovf_set = 1'b1;
          end else begin
            push    = 1'b1;
            add_nxt = jmp_add;
          end
        end else if (ret) begin
          if (empty) begin
            unf_set = 1'b1;
          end else begin
            pop     = 1'b1;
            add_nxt = top;
          end
        end else if (inc) begin
          add_nxt = add + STEP_V;
        end
      end
      HALT: begin
        if (resume) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  assign halted = (state == HALT);

endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8; address width in bits, legal range 4 to 16.
REQ-002 Parameter STEP, default 4; increment added on each inc, 1 <= STEP < 2^ADDR_W.
REQ-003 Parameter STACK_DEPTH, default 4; number of return-stack entries, a power of 2 >= 2.
REQ-004 clk  input  1  clock; all state changes on its rising edge, except reset.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 inc  input  1  advance PC by STEP.
REQ-007 jmp  input  1  load jmp_add into PC.
REQ-008 call  input  1  push the return address and load jmp_add into PC.
REQ-009 ret  input  1  pop the return stack into PC.
REQ-010 jmp_add  input  ADDR_W  target address for jmp and call.
REQ-011 halt  input  1  enter the HALT state.
REQ-012 resume  input  1  leave HALT and enter RUN.
REQ-013 add  output  ADDR_W  current PC (registered).
REQ-014 halted  output  1  high while in HALT.
REQ-015 depth  output  $clog2(STACK_DEPTH)+1  number of valid stack entries.
REQ-016 ovf  output  1  sticky flag: call attempted with the stack full.
REQ-017 unf  output  1  sticky flag: ret attempted with the stack empty.

Function
REQ-018 The FSM SHALL have two states, RUN and HALT, and SHALL reset to RUN.
REQ-019 In RUN, exactly one action SHALL be taken per cycle, in priority order: halt > jmp > call > ret > inc > hold.
REQ-020 halt in RUN SHALL move the FSM to HALT next cycle, hold add, and discard any other command in that cycle.
REQ-021 In HALT, add and the stack SHALL hold and every command except resume SHALL be ignored; resume SHALL return the FSM to RUN with no PC action that cycle.
REQ-022 jmp SHALL load add <= jmp_add; the stack is unchanged.
REQ-023 call with depth < STACK_DEPTH SHALL push (add+STEP) mod 2^ADDR_W, increment depth, and load add <= jmp_add, all in one cycle.
REQ-024 call with depth == STACK_DEPTH SHALL leave add and the stack unchanged and set ovf.
REQ-025 ret with depth > 0 SHALL load add <= top entry and decrement depth, all in one cycle.
REQ-026 ret with depth == 0 SHALL leave add unchanged and set unf.
REQ-027 inc SHALL load add <= (add+STEP) mod 2^ADDR_W; wrap-around is silent, with no flag.
REQ-028 Every action SHALL take effect on the first rising edge after its command is sampled, a latency of 1 cycle; jmp SHALL be strictly synchronous.
REQ-029 ovf and unf SHALL stay set until rst.
REQ-030 halted SHALL equal (state == HALT), decoded from registers only.

Reset
REQ-031 On rst, immediately and regardless of clk, the block SHALL set add=0, depth=0, ovf=0, unf=0, state=RUN and halted=0; stack entry contents need not be cleared.
REQ-032 rst asserted mid-operation, including in HALT or with a full stack, SHALL abandon all state; the first command after deassertion SHALL act on the reset values.
REQ-033 While rst is high, all commands SHALL be ignored.

Structure
REQ-034 Package pc_seq_pkg SHALL hold the default values of ADDR_W, STEP and STACK_DEPTH and the state enum (RUN, HALT).
REQ-035 The return stack SHALL be a sub-module named pc_return_stack, parameterised by width and depth, with push/pop/top/depth/full/empty ports and async reset of its pointer.
REQ-036 Top-level priority decode and the FSM SHALL stay in program_sequencer.

Verification (defaults ADDR_W=8, STEP=4, STACK_DEPTH=4)
REQ-037 Reset, then inc held for 3 cycles -> add = 0, 4, 8, 12; then add=252 with inc -> add = 0 and no flag raised.
REQ-038 From add=16: call jmp_add=0x40, then inc, then ret -> add = 0x40, 0x44, 0x14; depth = 1 then 0.
REQ-039 Five consecutive calls to 0x80 -> depth = 4 after the fourth; the fifth leaves add=0x80 and sets ovf; ret on an empty stack sets unf and holds add.
REQ-040 jmp and call both high with jmp_add=0x20 -> add=0x20, depth unchanged; halt with inc -> add held and halted=1; jmp in HALT is ignored; resume -> halted=0 and the next inc advances add.
REQ-041 rst pulsed asynchronously mid-cycle, with depth=3, ovf=1 and the FSM in HALT -> outputs go to their reset values before the next clk edge, and the next inc gives add=4.
